fm_scan_ctrl: RTL and testbench
===============================

FM_SCAN_CTRL -- requirements
Module: fm_scan_ctrl

Interface
REQ-001 Parameter CH_W, default 8, channel index width.
REQ-002 Parameter CLR_CYC, default 16, cycles held in CLEAR so the RSSI accumulator sees EOC edges while in the RSSI_DONE state.
REQ-003 Parameter TMO_CYC, default 2^20, MEASURE watchdog limit in clk cycles.
REQ-004 clk  in  1  single system clock; all logic SHALL be on its rising edge.
REQ-005 RSTn  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle scan request.
REQ-007 abort  in  1  one-cycle scan cancel.
REQ-008 ch_first, ch_last  in  CH_W  inclusive scan range, sampled on an accepted start.
REQ-009 settle_cyc  in  16  tuner settle time in cycles, sampled on an accepted start.
REQ-010 rssi_irq  in  1  RSSI-block completion pulse.
REQ-011 rssi_val  in  17  RSSI sum for the current channel, valid with rssi_irq.
REQ-012 FM_HW_state  out  4  drives the RSSI block: 0000 idle, 0001 tune, 0100 RSSI, 1000 RSSI_DONE.
REQ-013 tune_ch  out  CH_W, tune_req  out  1  channel and one-cycle tuner strobe.
REQ-014 best_ch  out  CH_W, best_rssi  out  17  strongest channel found and its value.
REQ-015 busy, scan_irq, err_range, err_tmo  out  1 each  status, end-of-scan pulse, error flags.

Function
REQ-016 FSM states SHALL be IDLE, TUNE, SETTLE, MEASURE, CLEAR, DONE; FM_HW_state = 0000 in IDLE/DONE, 0001 in TUNE/SETTLE, 0100 in MEASURE, 1000 in CLEAR.
REQ-017 IDLE: start with ch_first<=ch_last SHALL latch the inputs, set cur=ch_first, clear best_rssi/best_ch/err flags, and go to TUNE next cycle.
REQ-018 start with ch_first>ch_last SHALL set err_range for one scan attempt, stay in IDLE, assert no tune_req and no scan_irq.
REQ-019 TUNE SHALL last exactly 1 cycle, asserting tune_req with tune_ch=cur, then go to SETTLE.
REQ-020 SETTLE SHALL last settle_cyc cycles (0 treated as 1), then go to MEASURE.
REQ-021 MEASURE SHALL wait for rssi_irq; on rssi_irq, if rssi_val > best_rssi (strict), best_rssi<=rssi_val and best_ch<=cur; ties keep the earlier (lower) channel.
REQ-022 MEASURE exceeding TMO_CYC cycles without rssi_irq SHALL set err_tmo (sticky until the next accepted start), treat the value as 0, and proceed.
REQ-023 After MEASURE the FSM SHALL hold CLEAR for CLR_CYC cycles; then, if cur==ch_last, go to DONE; else cur<=cur+1 and go to TUNE.
REQ-024 cur SHALL never wrap; ch_last = 2^CH_W-1 SHALL end the scan without overflow.
REQ-025 DONE SHALL pulse scan_irq for exactly 1 cycle and return to IDLE next cycle; best_ch/best_rssi SHALL hold until the next accepted start.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 start while busy SHALL be ignored.
REQ-028 abort in any non-IDLE state SHALL force IDLE on the next edge with FM_HW_state=0000 and no scan_irq; results are partial but valid.
REQ-029 abort and start in the same IDLE cycle: start SHALL be taken; in the same busy cycle, abort SHALL be taken.
REQ-030 rssi_irq outside MEASURE SHALL be ignored.

Reset
REQ-031 RSTn low SHALL immediately force IDLE, FM_HW_state=0000, tune_ch=0, tune_req=0, best_ch=0, best_rssi=0, busy=0, scan_irq=0, err_range=0, err_tmo=0, all counters 0; reset mid-scan discards all results.

Structure
REQ-032 FM_HW_state encodings (0000/0001/0100/1000) SHALL live in the shared FM package, together with the 17-bit RSSI width constant used by the RSSI block.
REQ-033 The design SHALL be a single module; the settle/clear/timeout counters share one 20-bit down-counter.

Verification
REQ-034 ch_first=5, ch_last=7, settle_cyc=3, rssi_val 100/300/200 -> three tune_req pulses at ch 5,6,7; best_ch=6, best_rssi=300; one scan_irq.
REQ-035 Equal rssi_val 50 on ch 2..4 -> best_ch=2.
REQ-036 ch_first=9, ch_last=3 -> err_range=1, busy stays 0, no tune_req.
REQ-037 No rssi_irq on ch 1 with TMO_CYC=64 -> err_tmo=1 after 64 cycles, scan continues to ch_last, scan_irq asserted.
REQ-038 abort during SETTLE of 2nd channel -> next cycle IDLE, FM_HW_state=0000, no scan_irq; RSTn low mid-MEASURE -> all outputs at reset values asynchronously.
REQ-039 ch_first=ch_last=255 (CH_W=8) -> single measurement, DONE, no wrap to 0.

Source files
------------

// File: rtl/fm_scan_ctrl_pkg.sv
// rtl/fm_scan_ctrl_pkg.sv - shared FM constants, RSSI-block state encodings and scan FSM states
package fm_scan_ctrl_pkg;

    localparam int RSSI_W = 17;
    localparam int CNT_W  = 20;

    localparam logic [3:0] FM_HW_IDLE      = 4'b0000;
    localparam logic [3:0] FM_HW_TUNE      = 4'b0001;
    localparam logic [3:0] FM_HW_RSSI      = 4'b0100;
    localparam logic [3:0] FM_HW_RSSI_DONE = 4'b1000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TUNE,
        S_SETTLE,
        S_MEASURE,
        S_CLEAR,
        S_DONE
    } scan_state_e;

    function automatic logic [3:0] fm_hw_of(scan_state_e s);
        logic [3:0] hw;
        hw = FM_HW_IDLE;
        case (s)
            S_TUNE, S_SETTLE: hw = FM_HW_TUNE;
            S_MEASURE:        hw = FM_HW_RSSI;
            S_CLEAR:          hw = FM_HW_RSSI_DONE;
            default:          hw = FM_HW_IDLE;
        endcase
        return hw;
    endfunction

endpackage

// File: rtl/fm_scan_ctrl_if.sv
// rtl/fm_scan_ctrl_if.sv - scan control / tuner / RSSI signal bundle
interface fm_scan_ctrl_if #(
    parameter int CH_W = 8
) ();
    import fm_scan_ctrl_pkg::*;

    logic              start;
    logic              abort;
    logic [CH_W-1:0]   ch_first;
    logic [CH_W-1:0]   ch_last;
    logic [15:0]       settle_cyc;
    logic              rssi_irq;
    logic [RSSI_W-1:0] rssi_val;

    logic [3:0]        FM_HW_state;
    logic [CH_W-1:0]   tune_ch;
    logic              tune_req;
    logic [CH_W-1:0]   best_ch;
    logic [RSSI_W-1:0] best_rssi;
    logic              busy;
    logic              scan_irq;
    logic              err_range;
    logic              err_tmo;

    modport master (
        output start, abort, ch_first, ch_last, settle_cyc, rssi_irq, rssi_val,
        input  FM_HW_state, tune_ch, tune_req, best_ch, best_rssi,
               busy, scan_irq, err_range, err_tmo
    );

    modport slave (
        input  start, abort, ch_first, ch_last, settle_cyc, rssi_irq, rssi_val,
        output FM_HW_state, tune_ch, tune_req, best_ch, best_rssi,
               busy, scan_irq, err_range, err_tmo
    );

endinterface

// File: rtl/fm_scan_ctrl.sv
// rtl/fm_scan_ctrl.sv - FM channel scan sequencer: tune, settle, measure RSSI, keep the strongest
module fm_scan_ctrl
    import fm_scan_ctrl_pkg::*;
#(
    parameter int CH_W    = 8,
    parameter int CLR_CYC = 16,
    parameter int TMO_CYC = 1 << 20
) (
    input  logic           clk,
    input  logic           RSTn,
    fm_scan_ctrl_if.slave  bus
);

    // Counter reload values are "cycles - 1": a phase ends on the cycle the counter reads zero.
    localparam logic [CNT_W-1:0] TMO_LD = CNT_W'(TMO_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LD = CNT_W'(CLR_CYC - 1);

    scan_state_e       state_q;
    logic [CH_W-1:0]   cur_q;
    logic [CH_W-1:0]   last_q;
    logic [15:0]       settle_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CH_W-1:0]   best_ch_q;
    logic [RSSI_W-1:0] best_rssi_q;
    logic              err_range_q;
    logic              err_tmo_q;
    logic [CNT_W-1:0]  settle_ld;

    // A settle time of zero still spends one cycle in SETTLE.
    assign settle_ld = (settle_q == 16'd0) ? '0 : {4'b0000, settle_q - 16'd1};

    // Scan sequencer; one shared down-counter times SETTLE, MEASURE watchdog and CLEAR.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= S_IDLE;
            cur_q       <= '0;
            last_q      <= '0;
            settle_q    <= '0;
            cnt_q       <= '0;
            best_ch_q   <= '0;
            best_rssi_q <= '0;
            err_range_q <= 1'b0;
            err_tmo_q   <= 1'b0;
        end else if (state_q != S_IDLE && bus.abort) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.ch_first <= bus.ch_last) begin
                            cur_q       <= bus.ch_first;
                            last_q      <= bus.ch_last;
                            settle_q    <= bus.settle_cyc;
                            best_ch_q   <= '0;
                            best_rssi_q <= '0;
                            err_range_q <= 1'b0;
                            err_tmo_q   <= 1'b0;
                            state_q     <= S_TUNE;
                        end else begin
                            err_range_q <= 1'b1;
                        end
                    end
                end
                S_TUNE: begin
                    cnt_q   <= settle_ld;
                    state_q <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (cnt_q == '0) begin
                        cnt_q   <= TMO_LD;
                        state_q <= S_MEASURE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_MEASURE: begin
                    if (bus.rssi_irq) begin
                        if (bus.rssi_val > best_rssi_q) begin
                            best_rssi_q <= bus.rssi_val;
                            best_ch_q   <= cur_q;
                        end
                        cnt_q   <= CLR_LD;
                        state_q <= S_CLEAR;
                    end else if (cnt_q == '0) begin
                        // A missing measurement counts as zero, which can never beat best_rssi.
                        err_tmo_q <= 1'b1;
                        cnt_q     <= CLR_LD;
                        state_q   <= S_CLEAR;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (cnt_q == '0) begin
                        if (cur_q == last_q) begin
                            state_q <= S_DONE;
                        end else begin
                            cur_q   <= cur_q + CH_W'(1);
                            state_q <= S_TUNE;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.FM_HW_state = fm_hw_of(state_q);
    assign bus.tune_ch     = cur_q;
    assign bus.tune_req    = (state_q == S_TUNE);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.scan_irq    = (state_q == S_DONE);
    assign bus.best_ch     = best_ch_q;
    assign bus.best_rssi   = best_rssi_q;
    assign bus.err_range   = err_range_q;
    assign bus.err_tmo     = err_tmo_q;

endmodule

// File: tb/tb_fm_scan_ctrl.sv
// tb/tb_fm_scan_ctrl.sv - scoreboard bench for fm_scan_ctrl
module tb_fm_scan_ctrl;
    import fm_scan_ctrl_pkg::*;

    logic clk  = 1'b0;
    logic RSTn = 1'b0;

    always #5 clk = ~clk;

    fm_scan_ctrl_if #(.CH_W(8)) bus ();

    fm_scan_ctrl #(
        .CH_W    (8),
        .CLR_CYC (16),
        .TMO_CYC (64)
    ) dut (
        .clk  (clk),
        .RSTn (RSTn),
        .bus  (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  exp_tune_q[$];
    logic [24:0] exp_res_q[$];
    logic [16:0] rssi_tab[256];
    bit          silent[256];

    int          tune_cnt = 0;
    int          irq_cnt  = 0;
    int          tune_cyc = 0;
    int          clr_cyc  = 0;
    int          meas_cyc = 0;
    int          mcnt     = 0;
    logic [24:0] mon_res;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: pushes expected tune channels and the expected scan result.
    task automatic model_scan(input int first, input int last);
        int bc = 0;
        int br = 0;
        int v;
        for (int c = first; c <= last; c++) begin
            exp_tune_q.push_back(8'(c));
            v = silent[c] ? 0 : int'(rssi_tab[c]);
            if (v > br) begin
                br = v;
                bc = c;
            end
        end
        exp_res_q.push_back({8'(bc), 17'(br)});
    endtask

    task automatic start_scan(input int first, input int last, input int settle);
        @(negedge clk);
        bus.ch_first   = 8'(first);
        bus.ch_last    = 8'(last);
        bus.settle_cyc = 16'(settle);
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start      = 1'b0;
    endtask

    task automatic wait_irq(input int budget);
        int base = irq_cnt;
        int n    = 0;
        while (irq_cnt == base && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("scan_irq_seen", 32'(irq_cnt != base), 32'd1);
        @(negedge clk);
    endtask

    // RSSI block model: answers three cycles into MEASURE unless the channel is silent.
    always @(negedge clk) begin
        bus.rssi_irq = 1'b0;
        if (bus.FM_HW_state == FM_HW_RSSI && !silent[bus.tune_ch]) begin
            mcnt++;
            if (mcnt == 3) begin
                bus.rssi_irq = 1'b1;
                bus.rssi_val = rssi_tab[bus.tune_ch];
            end
        end else begin
            mcnt = 0;
        end
    end

    // Output monitor: pops scoreboard entries on tune_req and scan_irq, counts phase cycles.
    always @(negedge clk) begin
        if (RSTn) begin
            if (bus.tune_req) begin
                tune_cnt++;
                if (exp_tune_q.size() == 0)
                    check("tune_unexpected", 32'(bus.tune_ch), 32'hFFFF_FFFF);
                else
                    check("tune_ch", 32'(bus.tune_ch), 32'(exp_tune_q.pop_front()));
            end
            if (bus.scan_irq) begin
                irq_cnt++;
                if (exp_res_q.size() == 0) begin
                    check("irq_unexpected", 32'(bus.scan_irq), 32'd0);
                end else begin
                    mon_res = exp_res_q.pop_front();
                    check("best_ch", 32'(bus.best_ch), 32'(mon_res[24:17]));
                    check("best_rssi", 32'(bus.best_rssi), 32'(mon_res[16:0]));
                end
            end
            if (bus.FM_HW_state == FM_HW_TUNE) tune_cyc++;
            if (bus.FM_HW_state == FM_HW_RSSI_DONE) clr_cyc++;
            if (bus.FM_HW_state == FM_HW_RSSI && bus.tune_ch == 8'd1) meas_cyc++;
        end
    end

    int base_tune;
    int base_irq;
    int n;

    initial begin
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.ch_first   = '0;
        bus.ch_last    = '0;
        bus.settle_cyc = '0;
        for (int i = 0; i < 256; i++) rssi_tab[i] = '0;

        #2;
        check("rst_hw_state", 32'(bus.FM_HW_state), 32'd0);
        check("rst_tune_ch", 32'(bus.tune_ch), 32'd0);
        check("rst_tune_req", 32'(bus.tune_req), 32'd0);
        check("rst_best_ch", 32'(bus.best_ch), 32'd0);
        check("rst_best_rssi", 32'(bus.best_rssi), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_scan_irq", 32'(bus.scan_irq), 32'd0);
        check("rst_err_range", 32'(bus.err_range), 32'd0);
        check("rst_err_tmo", 32'(bus.err_tmo), 32'd0);
        repeat (2) @(negedge clk);
        RSTn = 1'b1;

        // Basic scan 5..7, strongest in the middle; a start mid-scan must be ignored.
        rssi_tab[5] = 17'd100; rssi_tab[6] = 17'd300; rssi_tab[7] = 17'd200;
        tune_cyc = 0; clr_cyc = 0; base_tune = tune_cnt; base_irq = irq_cnt;
        model_scan(5, 7);
        start_scan(5, 7, 3);
        @(negedge clk);
        bus.ch_first = 8'd0; bus.ch_last = 8'd1; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_irq(2000);
        check("t1_tune_count", 32'(tune_cnt - base_tune), 32'd3);
        check("t1_irq_count", 32'(irq_cnt - base_irq), 32'd1);
        check("t1_tune_settle_cycles", 32'(tune_cyc), 32'd12);
        check("t1_clear_cycles", 32'(clr_cyc), 32'd48);
        check("t1_busy_after", 32'(bus.busy), 32'd0);
        check("t1_best_ch_hold", 32'(bus.best_ch), 32'd6);

        // Ties keep the lowest channel.
        rssi_tab[2] = 17'd50; rssi_tab[3] = 17'd50; rssi_tab[4] = 17'd50;
        model_scan(2, 4);
        start_scan(2, 4, 1);
        wait_irq(2000);
        check("t2_best_ch_tie", 32'(bus.best_ch), 32'd2);

        // Inverted range is rejected.
        base_tune = tune_cnt; base_irq = irq_cnt;
        start_scan(9, 3, 2);
        for (int i = 0; i < 5; i++) begin
            check("t3_busy_idle", 32'(bus.busy), 32'd0);
            @(negedge clk);
        end
        check("t3_err_range", 32'(bus.err_range), 32'd1);
        check("t3_no_tune", 32'(tune_cnt - base_tune), 32'd0);
        check("t3_no_irq", 32'(irq_cnt - base_irq), 32'd0);

        // Silent channel 1 trips the watchdog; scan still completes.
        silent[1] = 1'b1; rssi_tab[2] = 17'd40; meas_cyc = 0;
        model_scan(1, 2);
        start_scan(1, 2, 2);
        wait_irq(2000);
        check("t4_err_tmo", 32'(bus.err_tmo), 32'd1);
        check("t4_meas_cycles", 32'(meas_cyc), 32'd64);
        check("t4_err_range_cleared", 32'(bus.err_range), 32'd0);
        silent[1] = 1'b0;

        // Top channel, zero settle: one measurement and no wrap.
        rssi_tab[255] = 17'd77; tune_cyc = 0; base_tune = tune_cnt;
        model_scan(255, 255);
        start_scan(255, 255, 0);
        wait_irq(2000);
        repeat (40) @(negedge clk);
        check("t5_tune_count", 32'(tune_cnt - base_tune), 32'd1);
        check("t5_settle_zero_cycles", 32'(tune_cyc), 32'd2);
        check("t5_busy_after", 32'(bus.busy), 32'd0);
        check("t5_err_tmo_cleared", 32'(bus.err_tmo), 32'd0);

        // Abort during SETTLE of the second channel.
        rssi_tab[10] = 17'd90; rssi_tab[11] = 17'd120; rssi_tab[12] = 17'd500;
        exp_tune_q.push_back(8'd10); exp_tune_q.push_back(8'd11);
        base_tune = tune_cnt; base_irq = irq_cnt;
        start_scan(10, 12, 5);
        n = 0;
        while (tune_cnt - base_tune < 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("t6_second_tune_seen", 32'(tune_cnt - base_tune), 32'd2);
        repeat (2) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("t6_abort_hw_state", 32'(bus.FM_HW_state), 32'd0);
        check("t6_abort_busy", 32'(bus.busy), 32'd0);
        check("t6_partial_best_ch", 32'(bus.best_ch), 32'd10);
        check("t6_partial_best_rssi", 32'(bus.best_rssi), 32'd90);
        repeat (60) @(negedge clk);
        check("t6_no_irq", 32'(irq_cnt - base_irq), 32'd0);
        check("t6_no_more_tune", 32'(tune_cnt - base_tune), 32'd2);

        // Asynchronous reset in the middle of MEASURE.
        silent[20] = 1'b1;
        exp_tune_q.push_back(8'd20);
        start_scan(20, 21, 1);
        n = 0;
        while (bus.FM_HW_state != FM_HW_RSSI && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t7_in_measure", 32'(bus.FM_HW_state), 32'(FM_HW_RSSI));
        #1 RSTn = 1'b0;
        #1;
        check("t7_rst_hw_state", 32'(bus.FM_HW_state), 32'd0);
        check("t7_rst_tune_ch", 32'(bus.tune_ch), 32'd0);
        check("t7_rst_busy", 32'(bus.busy), 32'd0);
        check("t7_rst_best_ch", 32'(bus.best_ch), 32'd0);
        check("t7_rst_best_rssi", 32'(bus.best_rssi), 32'd0);
        check("t7_rst_tune_req", 32'(bus.tune_req), 32'd0);
        @(negedge clk);
        RSTn = 1'b1;
        repeat (3) @(negedge clk);

        check("sb_tune_empty", 32'(exp_tune_q.size()), 32'd0);
        check("sb_result_empty", 32'(exp_res_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
